and_gate: RTL and testbench

// - Bitwise two-input AND with a zero-latency combinational output.
// - Also provides a one-cycle registered copy with a valid flag, reduction flags,
//   and a saturating count of all-ones results.
// - Leaf logic primitive for datapath masking/enable gating.
// - WIDTH=1 gives the plain single-bit gate.

---
 rtl/and_gate.sv | 59 +++++
 tb/tb_and_gate.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/and_gate.sv
// Bitwise AND with a combinational result, reduction flags and a registered copy one cycle later.
// Always accepts input with no backpressure; the counter of valid all-ones results saturates.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             y_all,
  output logic             y_any,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] all_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] res_q, res_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign y     = a & b;
  assign y_all = &y;
  assign y_any = |y;

  always_comb begin
    res_d = res_q;
    vld_d = in_valid;
    cnt_d = cnt_q;
    if (in_valid) begin
      res_d = y;
      // Stick at the top value rather than wrapping back to zero.
      if (y_all && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign y_q       = res_q;
  assign out_valid = vld_q;
  assign all_cnt   = cnt_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed checks on a 1-bit instance plus randomized checks on a 4-bit instance against a reference model.
module tb_and_gate;

  logic       clk;
  logic       rst;
  logic       a1, b1, v1;
  logic       y1, yall1, yany1, yq1, ov1;
  logic [1:0] cnt1;
  logic [3:0] a4, b4, y4, yq4;
  logic       v4, yall4, yany4, ov4;
  logic [2:0] cnt4;

  int checks = 0;
  int passed = 0;

  and_gate #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .y(y1), .y_all(yall1), .y_any(yany1), .y_q(yq1),
    .out_valid(ov1), .all_cnt(cnt1)
  );

  and_gate #(.WIDTH(4), .CNT_W(3)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
    .y(y4), .y_all(yall4), .y_any(yany4), .y_q(yq4),
    .out_valid(ov4), .all_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the 4-bit instance
  int         m_cnt;
  logic [3:0] m_yq;
  logic       m_ov;
  logic [3:0] m_y;
  logic       m_rst;

  initial begin
    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; v4 = 1'b0;

    // Exhaustive 1-bit truth table, held in reset to show y ignores it
    for (int i = 0; i < 4; i++) begin
      a1 = (i >= 2);
      b1 = (i % 2 == 1);
      #10;
      check($sformatf("tt_y_%0d", i),   32'(y1),    32'(i == 3));
      check($sformatf("tt_any_%0d", i), 32'(yany1), 32'(i == 3));
      check($sformatf("tt_all_%0d", i), 32'(yall1), 32'(i == 3));
    end

    // Reset held 2 clocks with active inputs
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    tick(); tick();
    check("rst_y",   32'(y1),   32'd1);
    check("rst_yq",  32'(yq1),  32'd0);
    check("rst_ov",  32'(ov1),  32'd0);
    check("rst_cnt", 32'(cnt1), 32'd0);

    // One-cycle latency, then hold of y_q when not valid
    rst = 1'b0;
    tick();
    check("lat_yq",  32'(yq1),  32'd1);
    check("lat_ov",  32'(ov1),  32'd1);
    check("lat_cnt", 32'(cnt1), 32'd1);
    a1 = 1'b0; v1 = 1'b0;
    #1;
    check("lat_y0", 32'(y1), 32'd0);
    tick();
    check("hold_ov",  32'(ov1),  32'd0);
    check("hold_yq",  32'(yq1),  32'd1);
    check("hold_cnt", 32'(cnt1), 32'd1);

    // Valid but not all-ones: y_q updates to 0, counter holds
    b1 = 1'b0; a1 = 1'b1; v1 = 1'b1;
    tick();
    check("nz_yq",  32'(yq1),  32'd0);
    check("nz_ov",  32'(ov1),  32'd1);
    check("nz_cnt", 32'(cnt1), 32'd1);

    // Saturation with CNT_W=2
    rst = 1'b1; tick(); rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), 32'(cnt1), 32'((i < 3) ? i : 3));
      check($sformatf("sat_yq_%0d", i),  32'(yq1),  32'd1);
    end

    // Mid-stream reset at all_cnt=2
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick();
    check("mid_pre_cnt", 32'(cnt1), 32'd2);
    rst = 1'b1;
    tick();
    check("mid_cnt", 32'(cnt1), 32'd0);
    check("mid_ov",  32'(ov1),  32'd0);
    check("mid_yq",  32'(yq1),  32'd0);
    rst = 1'b0;
    tick();
    check("resume_cnt", 32'(cnt1), 32'd1);
    check("resume_ov",  32'(ov1),  32'd1);
    v1 = 1'b0;

    // 4-bit directed patterns
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    check("w4_y",   32'(y4),    32'h8);
    check("w4_any", 32'(yany4), 32'd1);
    check("w4_all", 32'(yall4), 32'd0);
    a4 = 4'hF; b4 = 4'hF;
    #1;
    check("w4_allF", 32'(yall4), 32'd1);

    // Randomized run with occasional resets against the model
    rst = 1'b1; tick(); rst = 1'b0;
    m_cnt = 0; m_yq = 4'h0; m_ov = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3) == 0) begin
        a4 = 4'hF; b4 = 4'hF;
      end else begin
        a4 = 4'($urandom);
        b4 = 4'($urandom);
      end
      v4    = ($urandom_range(3) != 0);
      m_rst = ($urandom_range(24) == 0);
      rst   = m_rst;
      m_y   = a4 & b4;
      #1;
      check("rnd_y",   32'(y4),    32'(m_y));
      check("rnd_all", 32'(yall4), 32'(m_y == 4'hF));
      check("rnd_any", 32'(yany4), 32'(m_y != 4'h0));
      tick();
      if (m_rst) begin
        m_cnt = 0; m_yq = 4'h0; m_ov = 1'b0;
      end else if (v4) begin
        m_yq = m_y;
        m_ov = 1'b1;
        if (m_y == 4'hF && m_cnt < 7) m_cnt = m_cnt + 1;
      end else begin
        m_ov = 1'b0;
      end
      check("rnd_yq",  32'(yq4),  32'(m_yq));
      check("rnd_ov",  32'(ov4),  32'(m_ov));
      check("rnd_cnt", 32'(cnt4), 32'(m_cnt));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
